// File: rtl/io_write_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_write_bridge_pkg
// Description : Shared constants and types for the I/O write bridge:
//               address-space select, I/O register offsets and the
//               queued I/O write entry format.
// Revision    : 1.0 - initial release
// ============================================================================
package io_write_bridge_pkg;

  // cpu_a[17:16] value that selects the I/O space
  localparam logic [1:0] IO_SEL      = 2'b11;
  // I/O register offsets
  localparam logic [2:0] IO_OFF_UART = 3'h0;
  localparam logic [2:0] IO_OFF_STOP = 3'h4;

  // One queued I/O write: offset bit (cpu_a[2]) plus the data byte
  typedef struct packed {
    logic       off;
    logic [7:0] data;
  } io_entry_t;

  localparam int IO_ENTRY_W = $bits(io_entry_t);

  // Expand the stored offset bit back into the 3-bit register offset
  function automatic logic [2:0] entry_offset(input logic off);
    return {off, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_write_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with power-of-two depth. A push while full
//               is only taken when a pop happens in the same cycle; otherwise
//               the data is dropped. Pop on empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             wr_en;
  logic             rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop frees the slot a simultaneous push needs, so full+pop still writes
  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  // Occupancy update: unchanged when push and pop coincide
  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage array; contents need no reset because pointers define validity
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and count registers; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_write_bridge.sv
`default_nettype none
// ============================================================================
// Module      : io_write_bridge
// Description : Splits the cpu external memory bus into a pass-through RAM
//               port and a queued I/O write port. I/O writes are buffered and
//               drained to the UART while it has room; a registered ready
//               throttles the cpu before the queue can overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module io_write_bridge
  import io_write_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic [2:0]  io_a,
  output logic [7:0]  io_dout,
  output logic        io_wr,
  input  logic [7:0]  io_din,
  input  logic        io_buffer_full,
  output logic        overflow
);

  // Keep one free slot so the cpu's one-cycle reaction lag cannot overflow
  localparam logic [PTR_W:0] RDY_LIMIT = (PTR_W+1)'(FIFO_DEPTH - 2);

  logic           is_io;
  logic           accepted;
  logic           is_null_uart;
  logic           push_req;
  logic           push_ok;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [PTR_W:0] count;
  logic [PTR_W:0] count_next;
  io_entry_t      push_entry;
  io_entry_t      head_entry;
  logic           unused_addr_hi;

  logic           sel_io_q;
  logic           cpu_rdy_q;
  logic           io_wr_q;
  logic [2:0]     io_a_q;
  logic [7:0]     io_dout_q;
  logic           overflow_q;

  assign unused_addr_hi = ^cpu_a[31:18];

  assign is_io    = (cpu_a[17:16] == IO_SEL);
  assign accepted = rdy_in & cpu_rdy_q;

  // RAM side is a straight pass-through, write gated by acceptance
  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;
  assign ram_wr   = cpu_wr & ~is_io & accepted;

  // Read data follows whichever space was addressed one accepted cycle ago
  assign cpu_din  = sel_io_q ? io_din : ram_din;

  // Build the queue entry; null bytes to the UART carry nothing useful
  always_comb begin
    push_entry      = '0;
    push_entry.off  = cpu_a[2];
    push_entry.data = cpu_dout;
  end

  assign is_null_uart = (entry_offset(cpu_a[2]) == IO_OFF_UART) && (cpu_dout == 8'h00);
  assign push_req     = accepted & cpu_wr & is_io & ~is_null_uart;
  assign pop          = rdy_in & ~fifo_empty & ~io_buffer_full;
  assign push_ok      = push_req & (~fifo_full | pop);

  // Look-ahead occupancy used to compute the registered ready
  always_comb begin
    count_next = count;
    if (push_ok && !pop) begin
      count_next = count + 1'b1;
    end else if (!push_ok && pop) begin
      count_next = count - 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (IO_ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // Registered control/outputs: read select, ready, drain strobe, overflow
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sel_io_q   <= 1'b0;
      cpu_rdy_q  <= 1'b0;
      io_wr_q    <= 1'b0;
      io_a_q     <= 3'h0;
      io_dout_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      if (accepted) begin
        sel_io_q <= is_io;
      end
      cpu_rdy_q <= rdy_in & (count_next <= RDY_LIMIT);
      io_wr_q   <= pop;
      if (pop) begin
        io_a_q    <= entry_offset(head_entry.off);
        io_dout_q <= head_entry.data;
      end
      if (push_req && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign cpu_rdy  = cpu_rdy_q;
  assign io_wr    = io_wr_q;
  assign io_a     = io_a_q;
  assign io_dout  = io_dout_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_io_write_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_write_bridge
// Description : Directed self-checking bench for io_write_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_write_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic [2:0]  io_a;
  logic [7:0]  io_dout;
  logic        io_wr;
  logic [7:0]  io_din;
  logic        io_buffer_full;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ram_mem [0:511];
  logic [10:0] io_log [$];

  always #5 clk_in = ~clk_in;

  io_write_bridge #(.FIFO_DEPTH(8), .PTR_W(3)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .cpu_a          (cpu_a),
    .cpu_dout       (cpu_dout),
    .cpu_wr         (cpu_wr),
    .cpu_din        (cpu_din),
    .cpu_rdy        (cpu_rdy),
    .ram_a          (ram_a),
    .ram_dout       (ram_dout),
    .ram_wr         (ram_wr),
    .ram_din        (ram_din),
    .io_a           (io_a),
    .io_dout        (io_dout),
    .io_wr          (io_wr),
    .io_din         (io_din),
    .io_buffer_full (io_buffer_full),
    .overflow       (overflow)
  );

  // Simple synchronous RAM with one-cycle read latency
  initial begin
    for (int i = 0; i < 512; i++) ram_mem[i] = 8'h00;
  end
  always @(posedge clk_in) begin
    if (ram_wr) ram_mem[ram_a[8:0]] <= ram_dout;
    ram_din <= ram_mem[ram_a[8:0]];
  end

  // Record every I/O write strobe as {io_a, io_dout}
  always @(negedge clk_in) begin
    if (io_wr === 1'b1) io_log.push_back({io_a, io_dout});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; cpu_a = 32'h0; cpu_dout = 8'h00; cpu_wr = 1'b0;
    io_din = 8'h77; io_buffer_full = 1'b0;

    // ---------------- reset state ----------------
    tick(3);
    chk("rst_io_wr",    32'(io_wr),    32'h0);
    chk("rst_io_a",     32'(io_a),     32'h0);
    chk("rst_io_dout",  32'(io_dout),  32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_cpu_rdy",  32'(cpu_rdy),  32'h0);
    chk("rst_cpu_din",  32'(cpu_din),  32'h00);
    rst_in = 1'b1;
    tick();
    chk("rdy_after_rst", 32'(cpu_rdy), 32'h1);

    // ---------------- RAM pass-through ----------------
    cpu_a = 32'h0000_0100; cpu_dout = 8'hA5; cpu_wr = 1'b1;
    #1;
    chk("ram_wr_pulse", 32'(ram_wr),   32'h1);
    chk("ram_a",        32'(ram_a),    32'h00100);
    chk("ram_dout",     32'(ram_dout), 32'hA5);
    tick();
    cpu_wr = 1'b0;
    #1;
    chk("ram_rd_no_wr", 32'(ram_wr), 32'h0);
    tick();
    chk("ram_rd_data", 32'(cpu_din), 32'hA5);
    tick(2);
    chk("ram_no_io_wr", 32'(io_log.size()), 32'd0);

    // ---------------- UART order ----------------
    cpu_a = 32'h0003_0000; cpu_dout = 8'h48; cpu_wr = 1'b1;
    #1;
    chk("io_no_ram_wr", 32'(ram_wr), 32'h0);
    tick();
    cpu_dout = 8'h69;
    tick();
    cpu_wr = 1'b0;
    tick(4);
    chk("uart_cnt", 32'(io_log.size()), 32'd2);
    chk("uart_0",   32'(io_log[0]),     32'({3'd0, 8'h48}));
    chk("uart_1",   32'(io_log[1]),     32'({3'd0, 8'h69}));
    io_log.delete();

    // ---------------- Backpressure ----------------
    io_buffer_full = 1'b1;
    cpu_a = 32'h0003_0000; cpu_wr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cpu_dout = 8'(i + 1);
      tick();
      if (i == 5) chk("bp_rdy_at6", 32'(cpu_rdy), 32'h1);
    end
    chk("bp_rdy_at7", 32'(cpu_rdy), 32'h0);
    // Held write while not ready must not be taken
    cpu_dout = 8'hEE;
    tick(2);
    cpu_wr = 1'b0;
    tick();
    chk("bp_no_io_wr",   32'(io_log.size()), 32'd0);
    chk("bp_no_ovf",     32'(overflow),      32'h0);
    chk("bp_still_low",  32'(cpu_rdy),       32'h0);
    io_buffer_full = 1'b0;
    tick();
    chk("bp_rdy_back", 32'(cpu_rdy), 32'h1);
    chk("bp_first_wr", 32'(io_wr),   32'h1);
    chk("bp_first_d",  32'(io_dout), 32'h01);
    tick(10);
    chk("bp_cnt", 32'(io_log.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bp_data%0d", i), 32'(io_log[i]), 32'({3'd0, 8'(i + 1)}));
    end
    chk("bp_ovf_end", 32'(overflow), 32'h0);
    io_log.delete();

    // ---------------- Filter and stop ----------------
    cpu_wr = 1'b1;
    cpu_a = 32'h0003_0000; cpu_dout = 8'h00; tick();
    cpu_a = 32'h0003_0000; cpu_dout = 8'h41; tick();
    cpu_a = 32'h0003_0004; cpu_dout = 8'h5A; tick();
    cpu_wr = 1'b0;
    tick(5);
    chk("filt_cnt",  32'(io_log.size()), 32'd2);
    chk("filt_0",    32'(io_log[0]),     32'({3'd0, 8'h41}));
    chk("filt_stop", 32'(io_log[1]),     32'({3'd4, 8'h5A}));
    io_log.delete();

    // ---------------- Freeze and reset ----------------
    io_buffer_full = 1'b1;
    cpu_a = 32'h0003_0000; cpu_wr = 1'b1;
    cpu_dout = 8'h31; tick();
    cpu_dout = 8'h32; tick();
    cpu_dout = 8'h33; tick();
    cpu_wr = 1'b0;
    rdy_in = 1'b0; io_buffer_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("frz_io_wr%0d", i), 32'(io_wr), 32'h0);
    end
    chk("frz_rdy",  32'(cpu_rdy),       32'h0);
    chk("frz_log",  32'(io_log.size()), 32'd0);
    rdy_in = 1'b1;
    tick();
    chk("drain_wr", 32'(io_wr),   32'h1);
    chk("drain_d",  32'(io_dout), 32'h31);
    rst_in = 1'b0;
    tick();
    chk("mid_rst_io_wr",  32'(io_wr),    32'h0);
    chk("mid_rst_io_a",   32'(io_a),     32'h0);
    chk("mid_rst_io_d",   32'(io_dout),  32'h0);
    chk("mid_rst_rdy",    32'(cpu_rdy),  32'h0);
    chk("mid_rst_ovf",    32'(overflow), 32'h0);
    rst_in = 1'b1;
    tick();
    chk("mid_rst_rdy_up", 32'(cpu_rdy), 32'h1);
    tick(6);
    chk("flush_cnt", 32'(io_log.size()), 32'd1);
    io_log.delete();

    // ---------------- I/O read mux ----------------
    cpu_a = 32'h0003_0004; cpu_wr = 1'b0; io_din = 8'h12;
    tick();
    chk("io_rd_data", 32'(cpu_din), 32'h12);
    cpu_a = 32'h0000_0100;
    tick();
    chk("ram_rd_after_io", 32'(cpu_din), 32'hA5);
    tick(4);
    chk("io_rd_no_push", 32'(io_log.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
